// File: rtl/sd_pkg.sv
// Shared constants and helpers for the sequence detector slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sd_pkg;

    localparam logic SD_MODE_NONOVL = 1'b0;
    localparam logic SD_MODE_OVL    = 1'b1;

    localparam logic [3:0] SD_DEFAULT_PAT = 4'b1011;

    // Ceiling log2, used to size the window fill counter (clog2(PAT_W+1)).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((64'(1) << k) < 64'(value)) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Control/data bundle between a serial front-end and the sequence detector.
// Latency: n/a (wiring only).
// Backpressure: none; en qualifies each serial bit.
interface seq_detector_param_if #(
    parameter int PAT_W       = 4,
    parameter int MATCH_CNT_W = 8
);

    logic                   en;
    logic                   i;
    logic                   overlap;
    logic                   pat_ld;
    logic [PAT_W-1:0]       pat_in;
    logic                   clr;
    logic                   o;
    logic [MATCH_CNT_W-1:0] match_cnt;
    logic [PAT_W-1:0]       pattern;

    modport master (
        output en, i, overlap, pat_ld, pat_in, clr,
        input  o, match_cnt, pattern
    );

    modport slave (
        input  en, i, overlap, pat_ld, pat_in, clr,
        output o, match_cnt, pattern
    );

endinterface

// File: rtl/sd_window.sv
// Sliding history of received bits plus a saturating count of fresh samples.
// Latency: window_o/full_next_o are combinational views of the next window.
// Backpressure: none; shifts only when shift_i is high, flush_i restarts the fill count.
module sd_window
    import sd_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_i,
    input  logic             flush_i,
    input  logic             bit_i,
    output logic [PAT_W-1:0] window_o,
    output logic             full_next_o
);

    localparam int FILL_W = clog2(PAT_W + 1);

    // Only PAT_W-1 older bits are kept; the newest bit comes straight from bit_i.
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    assign window_o    = {hist_q, bit_i};
    assign full_next_o = (fill_q >= FILL_W'(PAT_W - 1));

    // History and fill registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Shift in a bit and bump fill (saturating); a flush wins over the fill increment.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (shift_i) begin
            hist_d = window_o[PAT_W-2:0];
            if (fill_q != FILL_W'(PAT_W)) begin
                fill_d = fill_q + 1'b1;
            end
        end
        if (flush_i) begin
            fill_d = '0;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial sync-word detector against a runtime-loadable PAT_W-bit pattern; build option SD_MATCH_CNT_EN adds a match counter.
// Latency: o pulses 1 clk after the sampling edge of the final pattern bit.
// Backpressure: none; samples taken only when en=1, pat_ld > clr > en drop lower-priority events.
module seq_detector_param
    import sd_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(SD_DEFAULT_PAT),
    parameter int               MATCH_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_detector_param_if.slave  bus
);

    logic             ev_load;
    logic             ev_clr;
    logic             ev_sample;
    logic             hit;
    logic             restart;
    logic [PAT_W-1:0] window;
    logic             full_next;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic             o_q, o_d;

    // Resolve event priority and detect a hit on the bit being sampled this cycle.
    always_comb begin
        ev_load   = bus.pat_ld;
        ev_clr    = !bus.pat_ld && bus.clr;
        ev_sample = !bus.pat_ld && !bus.clr && bus.en;
        hit       = ev_sample && full_next && (window == pattern_q);
        restart   = 1'b0;
        case (bus.overlap)
            SD_MODE_OVL:    restart = 1'b0;
            SD_MODE_NONOVL: restart = hit;
        endcase
    end

    sd_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_i     (ev_sample),
        .flush_i     (ev_load || ev_clr || restart),
        .bit_i       (bus.i),
        .window_o    (window),
        .full_next_o (full_next)
    );

    // Pattern register and match pulse with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= RST_PATTERN;
            o_q       <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            o_q       <= o_d;
        end
    end

    // Load a new pattern on pat_ld; o follows the hit of this cycle only.
    always_comb begin
        pattern_d = pattern_q;
        if (ev_load) begin
            pattern_d = bus.pat_in;
        end
        o_d = hit;
    end

    assign bus.o       = o_q;
    assign bus.pattern = pattern_q;

`ifdef SD_MATCH_CNT_EN
    logic [MATCH_CNT_W-1:0] cnt_q, cnt_d;

    // Match counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count every cycle that sets o, holding at all-ones; clr zeroes it.
    always_comb begin
        cnt_d = cnt_q;
        if (ev_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = {MATCH_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

`ifdef SD_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       t_rst_n  = 1'b0;
    logic       t_en     = 1'b0;
    logic       t_i      = 1'b0;
    logic       t_ov     = 1'b0;
    logic       t_ld     = 1'b0;
    logic [3:0] t_pin    = 4'd0;
    logic       t_clr    = 1'b0;

    seq_detector_param_if #(.PAT_W(4), .MATCH_CNT_W(8)) bus1 ();
    seq_detector_param_if #(.PAT_W(4), .MATCH_CNT_W(2)) bus2 ();

    assign bus1.en = t_en;   assign bus2.en = t_en;
    assign bus1.i = t_i;     assign bus2.i = t_i;
    assign bus1.overlap = t_ov; assign bus2.overlap = t_ov;
    assign bus1.pat_ld = t_ld;  assign bus2.pat_ld = t_ld;
    assign bus1.pat_in = t_pin; assign bus2.pat_in = t_pin;
    assign bus1.clr = t_clr;    assign bus2.clr = t_clr;

    seq_detector_param #(.PAT_W(4), .RST_PATTERN(4'b1011), .MATCH_CNT_W(8)) dut1 (
        .clk(clk), .rst_n(t_rst_n), .bus(bus1)
    );
    seq_detector_param #(.PAT_W(4), .RST_PATTERN(4'b1011), .MATCH_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(t_rst_n), .bus(bus2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: list of samples taken since the last fill restart.
    int         fresh[$];
    logic [3:0] m_pat  = 4'b1011;
    logic       m_o    = 1'b0;
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic model_step(input bit rst, input bit en, input bit b, input bit ov,
                              input bit ld, input logic [3:0] pin, input bit clr);
        int  v;
        bit  hit;
        hit = 1'b0;
        if (rst) begin
            fresh.delete(); m_pat = 4'b1011; m_o = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (ld) begin
            m_pat = pin; fresh.delete(); m_o = 1'b0;
        end else if (clr) begin
            fresh.delete(); m_o = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (en) begin
            fresh.push_back(int'(b));
            if (fresh.size() > 4) void'(fresh.pop_front());
            if (fresh.size() == 4) begin
                v = 0;
                for (int k = 0; k < 4; k++) v = v * 2 + fresh[k];
                hit = (v == int'(m_pat));
            end
            if (hit && !ov) fresh.delete();
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_o = hit;
        end else begin
            m_o = 1'b0;
        end
    endtask

    // Drive one cycle, advance the model, then compare both DUTs to it.
    task automatic apply(input bit rst, input bit en, input bit b, input bit ov,
                         input bit ld, input logic [3:0] pin, input bit clr, input string tag);
        t_rst_n = !rst; t_en = en; t_i = b; t_ov = ov; t_ld = ld; t_pin = pin; t_clr = clr;
        model_step(rst, en, b, ov, ld, pin, clr);
        @(posedge clk); #1;
        chk({tag, ".o"},       32'(bus1.o),         32'(m_o));
        chk({tag, ".cnt"},     32'(bus1.match_cnt), CNT_ON ? 32'(m_cnt8) : 32'd0);
        chk({tag, ".pattern"}, 32'(bus1.pattern),   32'(m_pat));
        chk({tag, ".o_w2"},    32'(bus2.o),         32'(m_o));
        chk({tag, ".cnt_w2"},  32'(bus2.match_cnt), CNT_ON ? 32'(m_cnt2) : 32'd0);
    endtask

    task automatic smp(input bit b, input bit ov, input string tag);
        apply(1'b0, 1'b1, b, ov, 1'b0, 4'd0, 1'b0, tag);
    endtask

    task automatic rst_cycle(input string tag);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, tag);
    endtask

    typedef struct {
        bit rst;
        bit b;
        bit ov;
        bit exp_o;
        int exp_cnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int ocnt;
        // Stream 1,0,1,1,0,1,1 against 1011: overlap hits at bits 4 and 7, non-overlap only at 4.
        vecs[0]  = '{1, 0, 1, 0, 0};
        vecs[1]  = '{0, 1, 1, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 0};
        vecs[3]  = '{0, 1, 1, 0, 0};
        vecs[4]  = '{0, 1, 1, 1, 1};
        vecs[5]  = '{0, 0, 1, 0, 1};
        vecs[6]  = '{0, 1, 1, 0, 1};
        vecs[7]  = '{0, 1, 1, 1, 2};
        vecs[8]  = '{1, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 0};
        vecs[12] = '{0, 1, 0, 1, 1};
        vecs[13] = '{0, 0, 0, 0, 1};
        vecs[14] = '{0, 1, 0, 0, 1};
        vecs[15] = '{0, 1, 0, 0, 1};

        // Reset state against constants.
        rst_cycle("reset");
        chk("reset_o",       32'(bus1.o),         32'd0);
        chk("reset_cnt",     32'(bus1.match_cnt), 32'd0);
        chk("reset_pattern", 32'(bus1.pattern),   32'hB);

        // Table-driven overlap / non-overlap streams.
        for (int n = 0; n < 16; n++) begin
            if (vecs[n].rst) rst_cycle($sformatf("tbl%0d", n));
            else smp(vecs[n].b, vecs[n].ov, $sformatf("tbl%0d", n));
            chk($sformatf("tbl%0d_o", n), 32'(bus1.o), 32'(vecs[n].exp_o));
            chk($sformatf("tbl%0d_cnt", n), 32'(bus1.match_cnt),
                CNT_ON ? 32'(vecs[n].exp_cnt) : 32'd0);
        end

        // Fill guard: pattern 0000 needs four real samples after reset.
        rst_cycle("fg_rst");
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, "fg_ld");
        chk("fg_pattern", 32'(bus1.pattern), 32'h0);
        for (int k = 0; k < 3; k++) begin
            smp(1'b0, 1'b1, "fg_s");
            chk("fg_early_o", 32'(bus1.o), 32'd0);
        end
        smp(1'b0, 1'b1, "fg_s4");
        chk("fg_fourth_o", 32'(bus1.o), 32'd1);

        // en gaps are ignored, then a mid-stream reset discards progress.
        rst_cycle("gap_rst");
        smp(1'b1, 1'b1, "gap"); smp(1'b0, 1'b1, "gap"); smp(1'b1, 1'b1, "gap");
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 4'd0, 1'b0, "gap_idle");
            chk("gap_idle_o", 32'(bus1.o), 32'd0);
        end
        smp(1'b1, 1'b1, "gap_last");
        chk("gap_match_o", 32'(bus1.o), 32'd1);
        smp(1'b1, 1'b1, "mr"); smp(1'b0, 1'b1, "mr"); smp(1'b1, 1'b1, "mr");
        rst_cycle("mr_rst");
        smp(1'b1, 1'b1, "mr_after");
        chk("midreset_no_match_o", 32'(bus1.o), 32'd0);

        // Counter saturation: 1111, eight ones -> five consecutive pulses.
        rst_cycle("sat_rst");
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, "sat_ld");
        ocnt = 0;
        for (int k = 1; k <= 8; k++) begin
            smp(1'b1, 1'b1, "sat");
            chk($sformatf("sat_o_bit%0d", k), 32'(bus1.o), (k >= 4) ? 32'd1 : 32'd0);
            if (bus1.o) ocnt++;
        end
        chk("sat_pulses", 32'(ocnt), 32'd5);
        chk("sat_cnt_w2", 32'(bus2.match_cnt), CNT_ON ? 32'd3 : 32'd0);
        chk("sat_cnt_w8", 32'(bus1.match_cnt), CNT_ON ? 32'd5 : 32'd0);

        // pat_ld with en on the same edge: sample dropped, fill restarted, count kept.
        rst_cycle("ld_rst");
        smp(1'b1, 1'b1, "ld"); smp(1'b0, 1'b1, "ld"); smp(1'b1, 1'b1, "ld"); smp(1'b1, 1'b1, "ld");
        chk("ld_first_o", 32'(bus1.o), 32'd1);
        smp(1'b0, 1'b1, "ld"); smp(1'b1, 1'b1, "ld");
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, "ld_both");
        chk("ld_both_o", 32'(bus1.o), 32'd0);
        chk("ld_both_cnt", 32'(bus1.match_cnt), CNT_ON ? 32'd1 : 32'd0);
        smp(1'b1, 1'b1, "ld_after"); smp(1'b0, 1'b1, "ld_after"); smp(1'b1, 1'b1, "ld_after");
        chk("ld_refill_o", 32'(bus1.o), 32'd0);
        smp(1'b1, 1'b1, "ld_after4");
        chk("ld_refill_match_o", 32'(bus1.o), 32'd1);

        // clr on the hit cycle suppresses the pulse and zeroes the counter.
        rst_cycle("clr_rst");
        smp(1'b1, 1'b1, "clr"); smp(1'b0, 1'b1, "clr"); smp(1'b1, 1'b1, "clr"); smp(1'b1, 1'b1, "clr");
        smp(1'b0, 1'b1, "clr"); smp(1'b1, 1'b1, "clr");
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, "clr_hit");
        chk("clr_hit_o", 32'(bus1.o), 32'd0);
        chk("clr_hit_cnt", 32'(bus1.match_cnt), 32'd0);
        chk("clr_hit_pattern", 32'(bus1.pattern), 32'hB);

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            apply($urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < 80,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0,
                  "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial-bit sequence detector. It is the successor to the fixed-pattern SD block.
- Samples one bit per qualified clock.
- Compares a sliding window against a runtime-loadable pattern of PAT_W bits.
- Emits a one-cycle match pulse.
- Supports overlapping and non-overlapping detection modes.
- Sits behind serial front-ends (UART/GPIO bit streams) as a framing/sync-word detector.

Parameters:
PAT_W, 4, pattern length in bits (2..32).
RST_PATTERN, 4'b1011, pattern register value after reset (width PAT_W).
MATCH_CNT_W, 8, width of saturating match counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
en  input  1  sample qualifier; i is consumed only when en=1.
i  input  1  serial data bit; first-received bit aligns to pattern MSB.
overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
pat_ld  input  1  load strobe for pat_in.
pat_in  input  PAT_W  new pattern value.
clr  input  1  clears window fill and match counter.
o  output  1  registered match pulse.
match_cnt  output  MATCH_CNT_W  saturating count of matches (SD_MATCH_CNT_EN only).
pattern  output  PAT_W  currently active pattern.

Behaviour:
- Reset, synchronous, rst_n=0 at posedge:
  - hist=0, fill=0, o=0, match_cnt=0, pattern=RST_PATTERN.
  - Reset mid-stream discards all partial progress.
- Priority per cycle: rst_n > pat_ld > clr > en.
  - A lower-priority event in the same cycle as a higher one is ignored; the sample is dropped.
- pat_ld=1:
  - pattern<=pat_in; fill<=0; o<=0.
  - match_cnt is unchanged.
- clr=1:
  - fill<=0; match_cnt<=0; o<=0.
  - pattern is unchanged.
- en=1 (no higher event):
  - Window: hist<={hist[PAT_W-2:0], i}.
  - Fill: fill<=min(fill+1, PAT_W); fill is a counter of width clog2(PAT_W+1).
  - Hit condition: hit = (fill>=PAT_W-1) && ({hist[PAT_W-2:0], i}==pattern).
  - Output: o<=hit, i.e. o is high on the cycle after the sampling edge of the final pattern bit. Latency is 1 clock.
  - On hit with overlap=0: fill<=0, so the next match needs PAT_W fresh bits.
  - On hit with overlap=1: fill stays saturated, so a match is possible on the very next sample.
- en=0: o<=0; hist and fill hold.
- o is never high for two consecutive cycles unless en is high in both and both samples hit (overlap mode only).
- match_cnt:
  - Increments on each cycle where o is set.
  - Saturates at all-ones; does not wrap.
- overlap is sampled live each en cycle. Changing it mid-stream affects only the next hit.
- The fill counter prevents false matches from reset-zero history (for example, pattern 0000 after reset needs 4 real samples).

Optional Feature:
SD_MATCH_CNT_EN
- Defined: match_cnt register and port present, behaving as above.
- Undefined:
  - match_cnt port is still present but tied to 0.
  - No counter flops are inferred.
  - clr affects fill only.

Decomposition:
Package sd_pkg holds:
- SD_MODE_NONOVL=1'b0 and SD_MODE_OVL=1'b1 constants.
- Function clog2 used for the fill width.
- Default pattern constant SD_DEFAULT_PAT=4'b1011.

One sub-module: sd_window, containing:
- The shift register and fill counter.
- Parameter PAT_W.
- Inputs: shift, flush, bit.
- Outputs: window and full_next.
The top holds the pattern register, compare, mode logic, o and the counter.

Test Plan:
1. PAT_W=4, pattern 1011, overlap=1, en=1 every cycle, stream 1,0,1,1,0,1,1 -> o pulses after bit 4 and after bit 7; match_cnt=2.
2. Same stream, overlap=0 -> o pulses only after bit 4; match_cnt=1.
3. After reset, pat_ld with pat_in=0000, then stream 0,0,0 -> no o. Fourth 0 -> o=1 one cycle later. Proves the fill guard.
4. Overlap=1, pattern 1011, stream 1,0,1 with en=1, then en=0 for 5 cycles, then 1 -> o=1 after the final sample (gaps are ignored). Then rst_n=0 mid-stream 1,0,1 followed by 1 -> no match.
5. MATCH_CNT_W=2, pattern 1111, overlap=1, eight 1s -> o high for 5 consecutive cycles; match_cnt saturates at 3, not wrapping to 1.
6. Simultaneous events:
   - pat_ld=1, en=1, i=1 at the same edge -> sample dropped, fill=0, pattern updated.
   - clr=1 with en=1 on the hit cycle -> o stays 0 and match_cnt=0.
